// File: rtl/j1_uart_io.sv
// j1_uart_io: memory-mapped UART for the J1 CPU.
// DATA at 16'h1000, FLAGS at 16'h2000, IRQEN at 16'h4000. The receive path has a 2-flop
// synchronizer, a start-bit glitch filter, and framing-error detection.
// Build option J1_UART_RX_FIFO_EN: when defined, received bytes go into a 2^RXDEPTHBITS-entry
// FIFO. When undefined, they go into a single holding register.
module j1_uart_io #(
  parameter int unsigned CLKDIV      = 104,
  parameter int unsigned RXDEPTHBITS = 4
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [63:0] io_addr,
  input  logic [63:0] io_dout,
  output logic [63:0] io_din,
  output logic        interrupt_request,
  input  logic        uart_rx,
  output logic        uart_tx
);
  localparam int unsigned DivW = $clog2(CLKDIV);
  localparam logic [DivW-1:0] DivFull = DivW'(CLKDIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLKDIV / 2 - 1);
  localparam logic [DivW-1:0] DivOne  = DivW'(1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

  logic       sel_data, sel_flags, sel_irqen;
  logic       data_rd, flags_rd, data_wr, irqen_wr;
  logic       irq_en, overrun, frame_err;
  logic       rx_avail, rx_full, pop;
  logic [7:0] rx_head;
  logic       unused_io;

  assign sel_data  = io_addr[15:0] == 16'h1000;
  assign sel_flags = io_addr[15:0] == 16'h2000;
  assign sel_irqen = io_addr[15:0] == 16'h4000;
  assign data_rd   = io_rd & sel_data;
  assign flags_rd  = io_rd & sel_flags;
  assign data_wr   = io_wr & sel_data;
  assign irqen_wr  = io_wr & sel_irqen;
  assign pop       = data_rd & rx_avail;
  assign unused_io = ^{io_addr[63:16], io_dout[63:8]};

  // ---------------- transmitter ----------------
  logic            tx_busy;
  logic [8:0]      tx_shift;
  logic [3:0]      tx_bits;
  logic [DivW-1:0] tx_div;

  // Transmit shifter: the start bit is driven on the write edge; then 8 data bits and the stop bit.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_busy  <= 1'b0;
      tx_shift <= '0;
      tx_bits  <= '0;
      tx_div   <= '0;
      uart_tx  <= 1'b1;
    end else if (!tx_busy) begin
      if (data_wr) begin
        tx_busy  <= 1'b1;
        uart_tx  <= 1'b0;
        tx_shift <= {1'b1, io_dout[7:0]};
        tx_bits  <= 4'd9;
        tx_div   <= DivFull;
      end
    end else if (tx_div != '0) begin
      tx_div <= tx_div - DivOne;
    end else if (tx_bits == '0) begin
      tx_busy <= 1'b0;  // stop bit has been held a full bit time
    end else begin
      uart_tx  <= tx_shift[0];
      tx_shift <= {1'b0, tx_shift[8:1]};
      tx_bits  <= tx_bits - 4'd1;
      tx_div   <= DivFull;
    end
  end

  // ---------------- receiver ----------------
  logic            rx_s1, rx_s2, rx_prev;
  rx_state_e       rx_state;
  logic [DivW-1:0] rx_div;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_push, rx_ferr;

  // Synchronizer plus a delayed copy that is used for falling-edge detection; all flops idle high.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receive FSM: samples at mid-bit and emits one-cycle push / framing-error pulses.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_state <= StIdle;
      rx_div   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_push  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_state)
        StIdle: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= StStart;
            rx_div   <= DivHalf;
          end
        end
        StStart: begin
          if (rx_div != '0) begin
            rx_div <= rx_div - DivOne;
          end else if (!rx_s2) begin
            rx_state <= StData;
            rx_div   <= DivFull;
            rx_bit   <= '0;
          end else begin
            rx_state <= StIdle;  // a pulse this short is treated as a glitch
          end
        end
        StData: begin
          if (rx_div != '0) begin
            rx_div <= rx_div - DivOne;
          end else begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_div   <= DivFull;
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= StStop;
          end
        end
        StStop: begin
          if (rx_div != '0) begin
            rx_div <= rx_div - DivOne;
          end else begin
            rx_push  <= rx_s2;
            rx_ferr  <= !rx_s2;
            rx_state <= StIdle;
          end
        end
        default: rx_state <= StIdle;
      endcase
    end
  end

  // ---------------- receive buffer ----------------
`ifdef J1_UART_RX_FIFO_EN
  localparam int unsigned Depth = 2 ** RXDEPTHBITS;
  localparam logic [RXDEPTHBITS-1:0] PtrOne = RXDEPTHBITS'(1);

  logic [7:0]             mem [Depth];
  logic [RXDEPTHBITS-1:0] wptr, rptr;
  logic [RXDEPTHBITS:0]   count;
  logic                   push_ok;

  assign rx_avail = count != '0;
  assign rx_full  = count[RXDEPTHBITS];
  assign rx_head  = mem[rptr];
  assign push_ok  = rx_push & (!rx_full | pop);

  // Storage array; its contents are only meaningful between rptr and wptr.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= rx_shift;
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PtrOne;
      if (pop)     rptr <= rptr + PtrOne;
      count <= count + {{RXDEPTHBITS{1'b0}}, push_ok} - {{RXDEPTHBITS{1'b0}}, pop};
    end
  end
`else
  logic [7:0] hold;
  logic       hold_full;
  logic       unused_depth;

  assign rx_avail     = hold_full;
  assign rx_full      = hold_full;
  assign rx_head      = hold;
  assign unused_depth = RXDEPTHBITS != 0;

  // Single holding register; a push that comes with a pop replaces the byte being read.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (rx_push && (!hold_full || pop)) begin
      hold      <= rx_shift;
      hold_full <= 1'b1;
    end else if (pop) begin
      hold_full <= 1'b0;
    end
  end
`endif

  // Control and sticky status. A new error event takes priority over a clear from a FLAGS read.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      irq_en            <= 1'b0;
      overrun           <= 1'b0;
      frame_err         <= 1'b0;
      interrupt_request <= 1'b0;
    end else begin
      if (irqen_wr) irq_en <= io_dout[0];
      if (rx_push && rx_full && !pop) overrun <= 1'b1;
      else if (flags_rd)              overrun <= 1'b0;
      if (rx_ferr)       frame_err <= 1'b1;
      else if (flags_rd) frame_err <= 1'b0;
      interrupt_request <= irq_en & rx_avail;
    end
  end

  // Read mux: combinational, so the data is valid in the same cycle as io_rd.
  always_comb begin
    io_din = '0;
    if (sel_data) begin
      io_din[7:0] = rx_avail ? rx_head : 8'h00;
    end else if (sel_flags) begin
      io_din[4:0] = {frame_err, irq_en, overrun, rx_avail, tx_busy};
    end
  end

endmodule

// File: tb/tb_j1_uart_io.sv
// Self-checking bench for j1_uart_io with CLKDIV=8. The expected receive depth follows
// J1_UART_RX_FIFO_EN (16 when it is defined, 1 otherwise).
module tb_j1_uart_io;
  localparam int unsigned ClkDiv    = 8;
  localparam int unsigned DepthBits = 4;
`ifdef J1_UART_RX_FIFO_EN
  localparam int Depth = 1 << DepthBits;
`else
  localparam int Depth = 1;
`endif
  localparam logic [15:0] AData  = 16'h1000;
  localparam logic [15:0] AFlags = 16'h2000;
  localparam logic [15:0] AIrq   = 16'h4000;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [63:0] io_addr = '0;
  logic [63:0] io_dout = '0;
  logic [63:0] io_din;
  logic        interrupt_request;
  logic        uart_rx = 1'b1;
  logic        uart_tx;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs[14];
  logic [7:0]  q[$];
  logic        ovr_m, frm_m, irq_m;
  logic [63:0] d;

  j1_uart_io #(.CLKDIV(ClkDiv), .RXDEPTHBITS(DepthBits)) dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
    .io_dout(io_dout), .io_din(io_din), .interrupt_request(interrupt_request),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, output logic [63:0] v);
    io_addr = {48'h0, a};
    io_rd = 1'b1;
    #1;
    v = io_din;
    @(posedge clk);
    #1;
    io_rd = 1'b0;
    io_addr = '0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] v);
    io_addr = {48'h0, a};
    io_dout = v;
    io_wr = 1'b1;
    @(posedge clk);
    #1;
    io_wr = 1'b0;
    io_addr = '0;
    io_dout = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      repeat (ClkDiv) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  // Model-side consequence of one received frame.
  task automatic model_rx(input logic [7:0] b, input logic stop);
    if (!stop) frm_m = 1'b1;
    else if (q.size() < Depth) q.push_back(b);
    else ovr_m = 1'b1;
  endtask

  task automatic tx_frame(input logic [7:0] b, input int inj);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    wr(AData, {56'h0, b});
    io_addr = {48'h0, AFlags};
    #1;
    for (int k = 0; k <= 80; k++) begin
      check($sformatf("tx cyc%0d {busy,tx}", k), {62'h0, io_din[0], uart_tx},
            (k < 80) ? {62'h0, 1'b1, frame[k / ClkDiv]} : 64'h1);
      if (k == inj) begin
        io_addr = {48'h0, AData};
        io_dout = {56'h0, ~b};
        io_wr = 1'b1;
        tick();
        io_wr = 1'b0;
        io_addr = {48'h0, AFlags};
        io_dout = '0;
        #1;
      end else begin
        tick();
      end
    end
    io_addr = '0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, AFlags,   64'h0, 64'h0};
    vecs[1]  = '{1'b0, AData,    64'h0, 64'h0};
    vecs[2]  = '{1'b0, 16'h3000, 64'h0, 64'h0};
    vecs[3]  = '{1'b1, AIrq,     64'h1, 64'h0};
    vecs[4]  = '{1'b0, AFlags,   64'h0, 64'h8};
    vecs[5]  = '{1'b1, 16'h4001, 64'h0, 64'h0};
    vecs[6]  = '{1'b0, AFlags,   64'h0, 64'h8};
    vecs[7]  = '{1'b1, AIrq,     64'hFFFF_FFFF_FFFF_FF00, 64'h0};
    vecs[8]  = '{1'b0, AFlags,   64'h0, 64'h0};
    vecs[9]  = '{1'b1, AIrq,     64'h8000_0000_0000_0003, 64'h0};
    vecs[10] = '{1'b0, AFlags,   64'h0, 64'h8};
    vecs[11] = '{1'b1, AIrq,     64'h0, 64'h0};
    vecs[12] = '{1'b0, AFlags,   64'h0, 64'h0};
    vecs[13] = '{1'b0, 16'h0000, 64'h0, 64'h0};

    // Reset state.
    repeat (3) tick();
    io_addr = {48'h0, AFlags};
    #1;
    check("reset flags", io_din, 64'h0);
    check("reset uart_tx", {63'h0, uart_tx}, 64'h1);
    check("reset irq", {63'h0, interrupt_request}, 64'h0);
    io_addr = '0;
    resetq = 1'b1;
    tick();

    // Register access table.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        wr(vecs[i].addr, vecs[i].wdata);
      end else begin
        rd(vecs[i].addr, d);
        check($sformatf("vec%0d read", i), d, vecs[i].exp);
      end
      check($sformatf("vec%0d irq", i), {63'h0, interrupt_request}, 64'h0);
    end

    // Transmit: a fixed pattern, then random bytes with an ignored write while busy.
    tx_frame(8'h55, 1000);
    tick();
    for (int i = 0; i < 2; i++) begin
      tx_frame(8'($urandom_range(0, 255)), int'($urandom_range(0, 78)));
      tick();
    end

    // Single received byte.
    send_byte(8'hA3, 1'b1);
    settle();
    rd(AFlags, d);
    check("a3 flags", d, 64'h2);
    rd(AData, d);
    check("a3 data", d, 64'h0000_0000_0000_00A3);
    rd(AData, d);
    check("a3 empty read", d, 64'h0);
    rd(AFlags, d);
    check("a3 flags after", d, 64'h0);

    // Short glitch on the line.
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (20) tick();
    rd(AFlags, d);
    check("glitch flags", d, 64'h0);
    rd(AData, d);
    check("glitch data", d, 64'h0);

    // Bad stop bit.
    send_byte(8'h5A, 1'b0);
    settle();
    rd(AFlags, d);
    check("ferr flags", d, 64'h10);
    rd(AData, d);
    check("ferr data", d, 64'h0);
    rd(AFlags, d);
    check("ferr cleared", d, 64'h0);

    // Overrun: one more byte than the buffer holds.
    for (int i = 0; i <= Depth; i++) send_byte(8'(i), 1'b1);
    settle();
    rd(AFlags, d);
    check("ovr flags", d, 64'h6);
    rd(AFlags, d);
    check("ovr cleared", d, 64'h2);
    for (int i = 0; i < Depth; i++) begin
      rd(AData, d);
      check($sformatf("ovr data%0d", i), d, 64'(i));
    end
    rd(AFlags, d);
    check("ovr drained", d, 64'h0);

    // Interrupt follows irq_en & rx_avail with one cycle of lag.
    wr(AIrq, 64'h1);
    send_byte(8'h7E, 1'b1);
    settle();
    check("irq raised", {63'h0, interrupt_request}, 64'h1);
    rd(AData, d);
    check("irq data", d, 64'h7E);
    check("irq still high", {63'h0, interrupt_request}, 64'h1);
    tick();
    check("irq fell", {63'h0, interrupt_request}, 64'h0);

    // Random receive traffic against the queue model.
    irq_m = 1'($urandom_range(0, 1));
    wr(AIrq, {63'h0, irq_m});
    ovr_m = 1'b0;
    frm_m = 1'b0;
    q.delete();
    for (int n = 0; n < 30; n++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        logic [7:0] b;
        logic       stop;
        b = 8'($urandom_range(0, 255));
        stop = ($urandom_range(0, 7) != 0);
        send_byte(b, stop);
        model_rx(b, stop);
      end else if (op <= 7) begin
        rd(AData, d);
        check($sformatf("rand%0d data", n), d, (q.size() > 0) ? {56'h0, q.pop_front()} : 64'h0);
      end else begin
        rd(AFlags, d);
        check($sformatf("rand%0d flags", n), d,
              {59'h0, frm_m, irq_m, ovr_m, q.size() > 0, 1'b0});
        ovr_m = 1'b0;
        frm_m = 1'b0;
      end
      repeat (2) tick();
      check($sformatf("rand%0d irq", n), {63'h0, interrupt_request},
            {63'h0, irq_m && (q.size() > 0)});
    end
    while (q.size() > 0) begin
      rd(AData, d);
      check("rand drain", d, {56'h0, q.pop_front()});
    end
    rd(AFlags, d);
    wr(AIrq, 64'h0);

    // Read swept across the moment a byte arrives at a full buffer.
    for (int o = 0; o < 13; o++) begin
      int off;
      logic ov;
      off = 74 + o;
      for (int i = 0; i < Depth; i++) send_byte(8'(8'h20 + i), 1'b1);
      settle();
      fork
        send_byte(8'(8'hC0 + o), 1'b1);
        begin
          repeat (off) tick();
          rd(AData, d);
        end
      join
      settle();
      check($sformatf("sweep%0d head", o), d, 64'h20);
      rd(AFlags, d);
      ov = d[2];
      if (o == 0)  check("sweep early no overrun", {63'h0, ov}, 64'h0);
      if (o == 12) check("sweep late overrun", {63'h0, ov}, 64'h1);
      for (int i = 1; i < Depth; i++) begin
        rd(AData, d);
        check($sformatf("sweep%0d data%0d", o, i), d, 64'(8'h20 + i));
      end
      if (!ov) begin
        rd(AData, d);
        check($sformatf("sweep%0d new byte", o), d, 64'(8'hC0 + o));
      end
      rd(AData, d);
      check($sformatf("sweep%0d empty", o), d, 64'h0);
    end

    // Reset in the middle of a transmit frame, with state pending everywhere.
    wr(AIrq, 64'h1);
    send_byte(8'h33, 1'b1);
    settle();
    check("pre-reset irq", {63'h0, interrupt_request}, 64'h1);
    wr(AData, 64'h86);
    repeat (5 * ClkDiv + 3) tick();
    check("pre-reset tx bit4", {63'h0, uart_tx}, 64'h0);
    #2;
    resetq = 1'b0;
    #1;
    check("async reset tx", {63'h0, uart_tx}, 64'h1);
    check("async reset irq", {63'h0, interrupt_request}, 64'h0);
    tick();
    resetq = 1'b1;
    tick();
    rd(AFlags, d);
    check("post-reset flags", d, 64'h0);
    rd(AData, d);
    check("post-reset data", d, 64'h0);
    repeat (ClkDiv * 2) tick();
    check("post-reset tx idle", {63'h0, uart_tx}, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
